// File: rtl/img_fix_pkg.sv
// Shared fixed-point constants, helpers and types for the image-filter datapath.
package img_fix_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned PROD_W     = 16;
  localparam int unsigned KTAPS      = 9;
  localparam int unsigned COEF_SHIFT = 6;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_START,
    OP_ADD,
    OP_FINAL
  } acc_op_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Clamp a signed value into the unsigned range [0, 2^width - 1].
  function automatic logic [31:0] sat_u(input logic signed [63:0] value,
                                        input int unsigned width);
    logic signed [63:0] maxv;
    maxv = (64'sd1 <<< width) - 64'sd1;
    if (value < 0) return '0;
    if (value > maxv) return 32'(maxv);
    return 32'(value);
  endfunction

endpackage

// File: rtl/kernel_acc_round_sat.sv
// Combinational round-half-up, arithmetic right shift and unsigned saturation.
module round_sat
  import img_fix_pkg::*;
#(
  parameter int unsigned ACC_W = 20,
  parameter int unsigned SHIFT = COEF_SHIFT,
  parameter int unsigned OUT_W = PIX_W
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [OUT_W-1:0] pix
);

  // One extra bit so the rounding constant can never wrap the sum.
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;
  logic signed [63:0]    r64;

  always_comb begin
    biased  = (ACC_W + 1)'(sum) + HALF;
    shifted = biased >>> SHIFT;
    r64     = 64'(shifted);
    pix     = OUT_W'(sat_u(r64, OUT_W));
  end

endmodule

// File: rtl/kernel_acc.sv
// Accumulates TAPS signed products per pixel, then rounds, shifts and saturates
// into an unsigned pixel presented on a valid/ready output register.
module kernel_acc
  import img_fix_pkg::*;
#(
  parameter int unsigned IN_W  = PROD_W,
  parameter int unsigned TAPS  = KTAPS,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned SHIFT = COEF_SHIFT,
  parameter int unsigned OUT_W = PIX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic       [OUT_W-1:0] out_pix,
  output logic                   sync_err
);

  localparam int unsigned        CNT_W = clog2(TAPS);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TAPS - 1);

  // With this width the sum of TAPS full-scale products can never wrap.
  if (ACC_W < IN_W + clog2(TAPS)) begin : g_acc_w_check
    $error("kernel_acc: ACC_W too narrow for IN_W and TAPS");
  end

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0] tap_cnt, tap_d;
  logic                    valid_d, err_d;
  logic        [OUT_W-1:0] pix_d, pix_rnd;
  logic signed [ACC_W-1:0] data_x, sum;
  logic                    accept, drain;
  acc_op_e                 op;

  always_comb begin
    in_ready = ~out_valid | out_ready;
    accept   = ce & in_valid & in_ready;
    drain    = ce & out_valid & out_ready;
    data_x   = ACC_W'(in_data);
    sum      = acc_q + data_x;
  end

  round_sat #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_round_sat (
    .sum(sum),
    .pix(pix_rnd)
  );

  // in_first always restarts, even at the last tap position.
  always_comb begin
    op = OP_HOLD;
    if (accept) begin
      if (in_first)             op = OP_START;
      else if (tap_cnt == LAST) op = OP_FINAL;
      else                      op = OP_ADD;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    tap_d   = tap_cnt;
    pix_d   = out_pix;
    err_d   = sync_err;
    valid_d = drain ? 1'b0 : out_valid;
    case (op)
      OP_START: begin
        acc_d = data_x;
        tap_d = CNT_W'(1);
        if (tap_cnt != '0) err_d = 1'b1;
      end
      OP_ADD: begin
        acc_d = sum;
        tap_d = tap_cnt + CNT_W'(1);
      end
      OP_FINAL: begin
        acc_d   = '0;
        tap_d   = '0;
        pix_d   = pix_rnd;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      tap_cnt   <= '0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      sync_err  <= 1'b0;
    end else if (ce) begin
      acc_q     <= acc_d;
      tap_cnt   <= tap_d;
      out_valid <= valid_d;
      out_pix   <= pix_d;
      sync_err  <= err_d;
    end
  end

endmodule

// File: doc/kernel_acc.md
Name: kernel_acc

Overview:
- Downstream consumer of the fixed-point multiply/add stage (mul36, fix_add) in the image-filter datapath.
- Takes a stream of signed per-tap products for a 3x3 kernel and accumulates TAPS products per output pixel.
- Rounds, arithmetic-right-shifts by the coefficient scale, and saturates to an unsigned 8-bit pixel.
- Presents the pixel on a valid/ready handshake to the write-back stage.

Parameters:
- IN_W, 16, width of the signed two's-complement product input.
- TAPS, 9, number of products summed per output pixel (range 2..16).
- ACC_W, 20, accumulator width; must be >= IN_W + ceil(log2(TAPS)).
- SHIFT, 6, coefficient fractional bits, so output = round(sum / 2^SHIFT); SHIFT >= 1.
- OUT_W, 8, unsigned output pixel width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state holds and no handshake completes.
- in_valid  in  1  product available.
- in_first  in  1  qualifies in_data as tap 0 of a new kernel.
- in_data  in  IN_W  signed product.
- in_ready  out  1  stage can accept a product this cycle.
- out_valid  out  1  pixel held in output register.
- out_ready  in  1  downstream accepts pixel.
- out_pix  out  OUT_W  saturated pixel.
- sync_err  out  1  sticky; kernel restarted before TAPS products were collected.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Reset dominates ce.
- Reset values: acc=0, tap_cnt=0, out_valid=0, out_pix=0, sync_err=0. Reset mid-kernel discards the partial sum and any held pixel.
- Accept condition: accept = ce & in_valid & in_ready.
- in_ready = ~out_valid | out_ready. This is combinational from out_ready and is never dependent on in_valid.
- Output drain: out_valid clears on ce & out_valid & out_ready, unless a new pixel is loaded in the same cycle, in which case it stays 1.
- States, encoded by tap_cnt (0..TAPS-1): tap_cnt==0 is IDLE/FIRST; all other values are ACCUM.
- On accept with in_first=1:
  - acc <= sext(in_data), tap_cnt <= 1.
  - If tap_cnt != 0, set sync_err (the partial kernel is dropped).
- On accept with in_first=0 and tap_cnt < TAPS-1: acc <= acc + sext(in_data), tap_cnt++.
  - in_first=0 at tap_cnt==0 is legal and is treated as tap 0.
- On accept at tap_cnt == TAPS-1 (final tap):
  - sum = acc + sext(in_data), at full ACC_W.
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, computed at ACC_W+1 bits so that adding the rounding constant cannot wrap.
  - out_pix <= 0 if r < 0; (2^OUT_W - 1) if r > 2^OUT_W - 1; otherwise r[OUT_W-1:0].
  - out_valid <= 1, acc <= 0, tap_cnt <= 0.
- in_first together with TAPS==... the final-tap rule takes priority only if in_first=0; in_first always restarts.
- Latency: out_valid rises on the cycle after the final tap is accepted. Sustained throughput is one pixel per TAPS cycles.
- Back-pressure: while out_valid=1 and out_ready=0, in_ready=0; the accumulator and tap_cnt hold. A simultaneous drain and final-tap load is allowed (full throughput).
- Accumulator wrap cannot occur with legal parameters. This is verified by an assertion on the ACC_W parameter check.
- sync_err clears only on rst.

Decomposition:
- Shared package img_fix_pkg holds:
  - constants PIX_W=8, PROD_W=16, KTAPS=9, COEF_SHIFT=6;
  - function clog2;
  - function sat_u(signed value, width) returning the clamped unsigned value.
- One natural sub-module: round_sat (combinational round, shift, and saturate), reused later by the normalization stage.
- Control (counter and handshake) stays in kernel_acc.

Test Plan:
- Nine products of 252 (36*7), in_first on the first, out_ready=1 -> out_pix=35 one cycle after the 9th accept; sync_err=0.
- Nine products of 9180 (36*255) -> sum 82620, r=1291 -> out_pix=255 (upper saturation).
- Nine products of -100 -> sum -900, r=-14 -> out_pix=0 (lower saturation).
- Three kernels back-to-back with out_ready held 0 after the first pixel -> in_ready=0, first pixel held stable. Release out_ready -> each remaining pixel appears in order; no product lost (scoreboard).
- in_first asserted at tap 5 of a kernel -> sync_err=1. The following 9 products of 64 give out_pix=9 (restart verified).
- Assert rst at tap 4 -> all outputs 0 next cycle. Then a full kernel of 128s gives out_pix=18.
